// File: rtl/keypad_scan_encoder_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map
// and row-pattern helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    HOLD     = 2'd3
  } state_t;

  localparam logic [3:0] KEY_STAR  = 4'hE;
  localparam logic [3:0] KEY_HASH  = 4'hF;
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // Indexed [row][col]; row 3 holds '*', '0', '#', 'D'.
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic single_low(input logic [3:0] rows);
    logic hit;
    case (rows)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
      default:                            hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!rows[i]) begin
        idx = 2'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_encoder_sync.sv
// Two-flop synchroniser for the asynchronous keypad rows; resets to the idle
// (all released) pattern so no phantom press is seen out of reset.
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1_r;
  logic [WIDTH-1:0] stage2_r;

  // Metastability filter: two back-to-back capture stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage1_r <= {WIDTH{1'b1}};
      stage2_r <= {WIDTH{1'b1}};
    end else begin
      stage1_r <= d;
      stage2_r <= stage1_r;
    end
  end

  assign q = stage2_r;

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad scanner, debouncer and key encoder; one enter strobe per press.
// Optional macro KEYPAD_CLEAR_OUT_EN adds a `clear` strobe used for the '*' key.
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] digit,
  output logic       enter
`ifdef KEYPAD_CLEAR_OUT_EN
  ,
  output logic       clear
`endif
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

  logic [3:0]       row_s;
  state_t           state_r,   state_nx;
  logic [1:0]       col_idx_r, col_idx_nx;
  logic [DIV_W-1:0] div_cnt_r, div_cnt_nx;
  logic [DEB_W-1:0] deb_cnt_r, deb_cnt_nx;
  logic [3:0]       pat_r,     pat_nx;
  logic [1:0]       key_row_r, key_row_nx;
  logic [3:0]       col_out_r;
  logic [3:0]       digit_r,   digit_nx;
  logic             enter_r,   enter_nx;
  logic [3:0]       code_s;
`ifdef KEYPAD_CLEAR_OUT_EN
  logic             clear_r,   clear_nx;
`endif

  keypad_sync #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_in),
    .q     (row_s)
  );

  assign code_s = KEY_MAP[key_row_r][col_idx_r];

  // Next-state logic: scan columns, debounce the latched pattern, emit, wait for release.
  always_comb begin
    state_nx   = state_r;
    col_idx_nx = col_idx_r;
    div_cnt_nx = div_cnt_r;
    deb_cnt_nx = deb_cnt_r;
    pat_nx     = pat_r;
    key_row_nx = key_row_r;
    case (state_r)
      SCAN: begin
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_nx = '0;
          if (single_low(row_s)) begin
            state_nx   = DEBOUNCE;
            pat_nx     = row_s;
            key_row_nx = low_index(row_s);
            deb_cnt_nx = '0;
          end else begin
            col_idx_nx = col_idx_r + 2'd1;
          end
        end else begin
          div_cnt_nx = div_cnt_r + DIV_W'(1);
        end
      end
      DEBOUNCE: begin
        if (row_s != pat_r) begin
          state_nx   = SCAN;
          col_idx_nx = col_idx_r + 2'd1;
          div_cnt_nx = '0;
          deb_cnt_nx = '0;
        end else if (deb_cnt_r == DEB_LAST) begin
          state_nx   = EMIT;
          deb_cnt_nx = '0;
        end else begin
          deb_cnt_nx = deb_cnt_r + DEB_W'(1);
        end
      end
      EMIT: begin
        state_nx   = HOLD;
        deb_cnt_nx = '0;
      end
      HOLD: begin
        // Only an unbroken run of idle cycles counts as a release.
        if (row_s != ROWS_IDLE) begin
          deb_cnt_nx = '0;
        end else if (deb_cnt_r == DEB_LAST) begin
          state_nx   = SCAN;
          col_idx_nx = 2'd0;
          div_cnt_nx = '0;
          deb_cnt_nx = '0;
        end else begin
          deb_cnt_nx = deb_cnt_r + DEB_W'(1);
        end
      end
      default: begin
        state_nx   = SCAN;
        col_idx_nx = 2'd0;
        div_cnt_nx = '0;
        deb_cnt_nx = '0;
      end
    endcase
  end

  // Output strobes, registered so they line up with the EMIT state.
  always_comb begin
    enter_nx = 1'b0;
    digit_nx = digit_r;
`ifdef KEYPAD_CLEAR_OUT_EN
    clear_nx = 1'b0;
    if (state_nx == EMIT) begin
      if (code_s == KEY_STAR) begin
        clear_nx = 1'b1;
      end else begin
        enter_nx = 1'b1;
        digit_nx = code_s;
      end
    end else begin
      clear_nx = 1'b0;
    end
`else
    if (state_nx == EMIT) begin
      enter_nx = 1'b1;
      digit_nx = code_s;
    end else begin
      enter_nx = 1'b0;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= SCAN;
      col_idx_r <= 2'd0;
      div_cnt_r <= '0;
      deb_cnt_r <= '0;
      pat_r     <= ROWS_IDLE;
      key_row_r <= 2'd0;
      col_out_r <= 4'b1110;
      digit_r   <= 4'h0;
      enter_r   <= 1'b0;
`ifdef KEYPAD_CLEAR_OUT_EN
      clear_r   <= 1'b0;
`endif
    end else begin
      state_r   <= state_nx;
      col_idx_r <= col_idx_nx;
      div_cnt_r <= div_cnt_nx;
      deb_cnt_r <= deb_cnt_nx;
      pat_r     <= pat_nx;
      key_row_r <= key_row_nx;
      col_out_r <= ~(4'b0001 << col_idx_nx);
      digit_r   <= digit_nx;
      enter_r   <= enter_nx;
`ifdef KEYPAD_CLEAR_OUT_EN
      clear_r   <= clear_nx;
`endif
    end
  end

  assign col_out = col_out_r;
  assign digit   = digit_r;
  assign enter   = enter_r;
`ifdef KEYPAD_CLEAR_OUT_EN
  assign clear   = clear_r;
`endif

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Randomised self-checking bench for keypad_scan_encoder: a physical keypad
// model drives the rows, and a press-level scoreboard checks every cycle.
module tb_keypad_scan_encoder;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;
  localparam int MIN_LAT      = 2 + DEBOUNCE_CNT + 1;
  localparam int MAX_LAT      = MIN_LAT + 4 * SCAN_DIV * 2;

  typedef struct {
    logic [3:0] code;
    bit         is_clear;
    int         press_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] digit;
  logic       enter;
  logic       clear_s;
  logic [15:0] pressed = 16'h0000;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses_seen = 0;
  logic [3:0] model_digit = 4'h0;
  exp_t exp_q[$];
  logic [3:0] seen_q[$];

  always #5 clk = ~clk;

  keypad_scan_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .clk     (clk),
    .reset   (reset),
    .row_in  (row_in),
    .col_out (col_out),
    .digit   (digit),
    .enter   (enter)
`ifdef KEYPAD_CLEAR_OUT_EN
    ,
    .clear   (clear_s)
`endif
  );
`ifndef KEYPAD_CLEAR_OUT_EN
  assign clear_s = 1'b0;
`endif

  // Physical keypad: a pressed key shorts its row to its column when driven low.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  function automatic logic [3:0] key_code(input int r, input int c);
    case (r * 4 + c)
      0: return 4'h1;  1: return 4'h2;  2: return 4'h3;  3: return 4'hA;
      4: return 4'h4;  5: return 4'h5;  6: return 4'h6;  7: return 4'hB;
      8: return 4'h7;  9: return 4'h8; 10: return 4'h9; 11: return 4'hC;
     12: return 4'hE; 13: return 4'h0; 14: return 4'hF; 15: return 4'hD;
      default: return 4'hX;
    endcase
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Compare process: every cycle checks reset values or the press-level model.
  bit rst_edge;
  bit prev_pulse = 1'b0;
  always begin
    exp_t e;
    @(posedge clk);
    cyc++;
    rst_edge = reset;
    @(negedge clk);
    if (rst_edge) begin
      check(col_out == 4'b1110, "reset_col_out", 32'(col_out), 32'h0000000E);
      check(digit == 4'h0, "reset_digit", 32'(digit), 32'h0);
      check(enter == 1'b0, "reset_enter", 32'(enter), 32'h0);
      check(clear_s == 1'b0, "reset_clear", 32'(clear_s), 32'h0);
      model_digit = 4'h0;
      exp_q.delete();
      prev_pulse = 1'b0;
    end else begin
      check($countones(~col_out) == 1, "col_onehot", 32'(col_out), 32'h0);
      if (enter || clear_s) begin
        pulses_seen++;
        check(!prev_pulse, "pulse_width", 32'(prev_pulse), 32'h0);
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_pulse", 32'({clear_s, enter}), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check(enter == !e.is_clear, "enter_kind", 32'(enter), 32'(!e.is_clear));
          check(clear_s == e.is_clear, "clear_kind", 32'(clear_s), 32'(e.is_clear));
          check(cyc - e.press_cyc >= MIN_LAT, "latency_min", 32'(cyc - e.press_cyc), 32'(MIN_LAT));
          check(cyc - e.press_cyc <= MAX_LAT, "latency_max", 32'(cyc - e.press_cyc), 32'(MAX_LAT));
          if (!e.is_clear) begin
            model_digit = e.code;
            seen_q.push_back(e.code);
          end
        end
      end
      check(digit == model_digit, "digit_hold", 32'(digit), 32'(model_digit));
      prev_pulse = enter || clear_s;
    end
  end

  task automatic expect_press(input int r, input int c);
    exp_t e;
    e.code = key_code(r, c);
`ifdef KEYPAD_CLEAR_OUT_EN
    e.is_clear = (e.code == 4'hE);
`else
    e.is_clear = 1'b0;
`endif
    e.press_cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic press_key(input int r, input int c, input int hold, input int rel, input bit expect_pulse);
    @(posedge clk); #1;
    pressed[r*4+c] = 1'b1;
    if (expect_pulse) expect_press(r, c);
    repeat (hold) @(posedge clk);
    #1;
    pressed = 16'h0000;
    repeat (rel) @(posedge clk);
    check(exp_q.size() == 0, "missing_pulse", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic wait_col(input logic [3:0] want, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = (col_out == want);
    end
    check(hit, "wait_col_timeout", 32'(col_out), 32'(want));
  endtask

  initial begin
    int p0;
    logic [3:0] want_seq [4];
    bit got;
    want_seq[0] = 4'h9; want_seq[1] = 4'h9; want_seq[2] = 4'h7; want_seq[3] = 4'h9;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);

    // 1: '9' once, column frozen during hold, scan resumes at column 0.
    @(posedge clk); #1;
    pressed[2*4+2] = 1'b1;
    expect_press(2, 2);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (got) check(col_out == 4'b1011, "hold_col_frozen", 32'(col_out), 32'hB);
      if (enter) begin
        got = 1'b1;
        check(digit == 4'h9, "first_digit", 32'(digit), 32'h9);
      end
    end
    check(got, "first_enter_seen", 32'(got), 32'h1);
    @(posedge clk); #1;
    pressed = 16'h0000;
    wait_col(4'b1110, 30);
    repeat (30) @(posedge clk);
    check(exp_q.size() == 0, "missing_pulse", 32'(exp_q.size()), 32'h0);

    // 2: sequence 9,9,7,9.
    seen_q.delete();
    press_key(2, 2, 60, 40, 1'b1);
    press_key(2, 2, 60, 40, 1'b1);
    press_key(2, 0, 60, 40, 1'b1);
    press_key(2, 2, 60, 40, 1'b1);
    check(seen_q.size() == 4, "seq_count", 32'(seen_q.size()), 32'h4);
    for (int i = 0; i < 4 && i < seen_q.size(); i++)
      check(seen_q[i] == want_seq[i], "seq_digit", 32'(seen_q[i]), 32'(want_seq[i]));

    // 3: bouncing '1' never settles.
    p0 = pulses_seen;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      pressed[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1 pressed[0] = 1'b0;
      repeat (2) @(posedge clk);
    end
    repeat (40) @(posedge clk);
    check(pulses_seen == p0, "bounce_no_enter", 32'(pulses_seen - p0), 32'h0);
    wait_col(4'b0111, 40);

    // 4: '1' and '4' together (ghost in one column).
    p0 = pulses_seen;
    @(posedge clk); #1;
    pressed[0] = 1'b1;
    pressed[4] = 1'b1;
    repeat (100) @(posedge clk);
    #1 pressed = 16'h0000;
    repeat (20) @(posedge clk);
    check(pulses_seen == p0, "multikey_no_enter", 32'(pulses_seen - p0), 32'h0);

    // 5: '5' with a reset mid-debounce.
    p0 = pulses_seen;
    wait_col(4'b1011, 40);
    wait_col(4'b1110, 20);
    @(posedge clk); #1;
    pressed[1*4+1] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    pressed = 16'h0000;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    check(pulses_seen == p0, "reset_no_enter", 32'(pulses_seen - p0), 32'h0);

    // 6: '*' held for a long time gives one pulse.
    p0 = pulses_seen;
    press_key(3, 0, 300, 40, 1'b1);
    check(pulses_seen - p0 == 1, "star_single", 32'(pulses_seen - p0), 32'h1);
`ifdef KEYPAD_CLEAR_OUT_EN
    check(digit == 4'h0, "star_digit_kept", 32'(digit), 32'h0);
`else
    check(digit == 4'hE, "star_digit", 32'(digit), 32'hE);
`endif

    // Random single-key presses.
    for (int n = 0; n < 12; n++) begin
      int k;
      k = $urandom_range(0, 15);
      press_key(k / 4, k % 4, $urandom_range(50, 70), $urandom_range(40, 50), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_scan_encoder.md
Name: keypad_scan_encoder

Overview:
- Upstream stage of the digital-lock `top`.
- Scans a 4x4 matrix keypad, synchronises and debounces the row inputs, and encodes the pressed key to a 4-bit code.
- Emits exactly one single-cycle `enter` pulse per debounced press, with `digit` valid on that cycle.
- Outputs connect directly to `top.digit` and `top.enter`.

Parameters:
- SCAN_DIV, 4: clock cycles each column is driven; rows are sampled on the last cycle of the window. Must be >=2.
- DEBOUNCE_CNT, 8: consecutive stable cycles required to accept a press or a release. Must be >=1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- row_in  in  4  keypad rows; active-low; pulled up externally; asynchronous
- col_out  out  4  column drive; active-low one-hot
- digit  out  4  key code of the last accepted press
- enter  out  1  one-cycle strobe; digit is valid on this cycle

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: col_out=4'b1110, digit=4'h0, enter=0, state=SCAN, column index=0, all counters=0.
- row_in passes through a 2-flop synchroniser; all logic uses the synchronised row_s.
- Key map, row r / col c to code:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: *=E, 0=0, #=F, D
- SCAN:
  - Drive column idx for SCAN_DIV cycles, then advance; column 3 wraps to 0.
  - On the last cycle of each window, sample row_s.
  - Exactly one bit low: latch row/col and pattern, go to DEBOUNCE, freeze column.
  - Zero bits low, or two or more low (ghost/multi-key): stay in SCAN.
- DEBOUNCE:
  - Each cycle, compare row_s with the latched pattern.
  - Mismatch: return to SCAN at the next column; no output.
  - Counter reaches DEBOUNCE_CNT-1 with a match: go to EMIT.
- EMIT (one cycle): enter=1, digit=code; then go to HOLD.
- HOLD:
  - Column stays frozen.
  - Counter counts consecutive cycles with row_s==4'b1111; any low bit clears it.
  - At DEBOUNCE_CNT: go to SCAN restarting at column 0.
  - A held key never produces a second enter.
- Outputs: enter is registered and high for exactly one cycle. digit holds its value until the next EMIT.
- Latency: from row_in settled low at a sample point to enter high is 2 (sync) + DEBOUNCE_CNT + 1 cycles.
- Reset mid-operation: reset asserted in any state aborts the press with no enter; the reset values apply on the next edge.
- Back-to-back presses: a release must be debounced before the next press is accepted, so a minimum gap between enters is guaranteed.

Optional Feature:
- Macro: KEYPAD_CLEAR_OUT_EN.
- Defined:
  - Adds output port `clear` (1 bit), a one-cycle strobe.
  - The '*' key (code E) pulses clear instead of enter; digit is unchanged.
- Undefined:
  - No clear port.
  - '*' is handled like any other key: enter pulses with digit=4'hE.

Decomposition:
- Package keypad_pkg:
  - State enum {SCAN, DEBOUNCE, EMIT, HOLD}
  - Key-map constant array [4][4] of 4-bit codes
  - KEY_STAR=4'hE, KEY_HASH=4'hF
  - ROWS_IDLE=4'b1111
- One sub-module: keypad_sync, a 2-flop synchroniser (4 bits wide), instantiated on row_in.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE_CNT=8, with a keypad model that pulls row r low while key(r,c) is pressed and col c is driven low.
1. Press '9' (r2,c2) for 60 cycles, then release -> exactly one enter, digit=4'h9. col_out frozen at 4'b1011 during HOLD.
2. Sequence 9,9,7,9, each held 60 cycles with 40 cycles released -> four enter pulses with digit 9,9,7,9. The downstream lock asserts unlocked after the fourth pulse.
3. Bounce: r0,c0 low for 3 cycles, high for 2, low for 3, then released -> no enter; scanning continues.
4. Keys '1' and '4' (same column, two rows low) held 100 cycles -> no enter, no state change beyond SCAN.
5. Press '5', assert reset for 1 cycle midway through DEBOUNCE -> no enter. Next cycle: col_out=4'b1110, digit=0.
6. Hold '*' for 300 cycles -> a single pulse: enter with digit=4'hE when the macro is undefined; clear=1 with enter=0 when KEYPAD_CLEAR_OUT_EN is defined.
